ram_arbiter: RTL and testbench

//  Two-port arbiter/sequencer in front of one single-port 16-bit RAM (RAM8..RAM16K family).

---
 rtl/ram_arb_pkg.sv | 8 +
 rtl/ram_arbiter_if.sv | 19 +
 rtl/ram_arbiter_rr_pick.sv | 17 +
 rtl/ram_arbiter.sv | 55 +++++
 tb/tb_ram_arbiter.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state encoding, master ids and default widths for the RAM arbiter
package ram_arb_pkg;
  localparam int AW_D = 7;
  localparam int DW_D = 16;
  localparam logic ID_M0 = 1'b0;
  localparam logic ID_M1 = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: two-master request/response bus plus the RAM control pins owned by the arbiter
interface ram_arbiter_if import ram_arb_pkg::*; #(parameter int AW = AW_D, parameter int DW = DW_D);
  logic req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wd0, wd1;
  logic gnt0, gnt1, rsp_valid, rsp_id, busy;
  logic [DW-1:0] rdata;
  logic ram_r, ram_w;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_d, ram_o;
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wd0, wd1, ram_o,
    output gnt0, gnt1, rsp_valid, rsp_id, busy, rdata, ram_r, ram_w, ram_addr, ram_d
  );
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wd0, wd1, ram_o,
    input  gnt0, gnt1, rsp_valid, rsp_id, busy, rdata, ram_r, ram_w, ram_addr, ram_d
  );
endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// rr_pick: picks the winning master; round-robin ties when RAM_ARB_RR_EN is defined, else master 0 wins
module rr_pick import ram_arb_pkg::*; (
  input  logic req0,
  input  logic req1,
  input  logic last_id,
  output logic win_id,
  output logic any
);
  always_comb begin
    any = req0 | req1;
`ifdef RAM_ARB_RR_EN
    win_id = (req0 & req1) ? ~last_id : (req1 ? ID_M1 : ID_M0);
`else
    win_id = req0 ? ID_M0 : (req1 ? ID_M1 : last_id);
`endif
  end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: IDLE->ACCESS->RESP sequencer sharing one single-port RAM between two masters
// Tie policy selected by RAM_ARB_RR_EN inside rr_pick.
module ram_arbiter import ram_arb_pkg::*; #(
  parameter int AW = AW_D,
  parameter int DW = DW_D
) (
  input logic clk,
  input logic rst_n,
  ram_arbiter_if.slave bus
);
  state_e state;
  logic id_q, we_q, last_id, win_id, any;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wd_q, rdata_q;
  rr_pick u_pick (
    .req0(bus.req0),
    .req1(bus.req1),
    .last_id(last_id),
    .win_id(win_id),
    .any(any)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      id_q <= ID_M0;
      we_q <= 1'b0;
      addr_q <= '0;
      wd_q <= '0;
      rdata_q <= '0;
      last_id <= ID_M1;
    end else if (state == IDLE && any) begin
      state <= ACCESS;
      id_q <= win_id;
      we_q <= win_id ? bus.we1 : bus.we0;
      addr_q <= win_id ? bus.addr1 : bus.addr0;
      wd_q <= win_id ? bus.wd1 : bus.wd0;
      last_id <= win_id;
    end else if (state == ACCESS) begin
      state <= RESP;
      if (!we_q) rdata_q <= bus.ram_o;
    end else if (state == RESP) begin
      state <= IDLE;
    end
  end
  assign bus.gnt0 = state == ACCESS && id_q == ID_M0;
  assign bus.gnt1 = state == ACCESS && id_q == ID_M1;
  assign bus.ram_r = state == ACCESS && !we_q;
  assign bus.ram_w = state == ACCESS && we_q;
  assign bus.ram_addr = addr_q;
  assign bus.ram_d = wd_q;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_id = id_q;
  assign bus.rdata = rdata_q;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vector table plus reset/tie/random sequences against a reference memory
module tb_ram_arbiter;
`ifdef RAM_ARB_RR_EN
  localparam logic RR = 1'b1;
`else
  localparam logic RR = 1'b0;
`endif
  typedef struct {
    logic r0, w0;
    logic [6:0] a0;
    logic [15:0] d0;
    logic r1, w1;
    logic [6:0] a1;
    logic [15:0] d1;
    logic eid;
    logic [15:0] erd;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic overlap = 1'b0;
  logic last_t;
  int checks = 0;
  int errors = 0;
  logic [15:0] mem [128];
  logic [15:0] ref_mem [128];
  vec_t vt [13];
  ram_arbiter_if #(.AW(7), .DW(16)) bus ();
  ram_arbiter #(.AW(7), .DW(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.ram_w) mem[bus.ram_addr] <= bus.ram_d;
  assign bus.ram_o = mem[bus.ram_addr];
  always @(negedge clk) if (bus.ram_r && bus.ram_w) overlap <= 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic txn(input vec_t v, input string nm);
    logic w;
    logic [6:0] a;
    logic [15:0] d;
    w = v.eid ? v.w1 : v.w0;
    a = v.eid ? v.a1 : v.a0;
    d = v.eid ? v.d1 : v.d0;
    bus.req0 = v.r0; bus.we0 = v.w0; bus.addr0 = v.a0; bus.wd0 = v.d0;
    bus.req1 = v.r1; bus.we1 = v.w1; bus.addr1 = v.a1; bus.wd1 = v.d1;
    @(posedge clk); #1;
    chk({nm, ":gnt"}, {28'd0, bus.gnt1, bus.gnt0, bus.ram_r, bus.ram_w}, {28'd0, v.eid, ~v.eid, ~w, w});
    chk({nm, ":addr"}, {25'd0, bus.ram_addr}, {25'd0, a});
    if (w) chk({nm, ":ram_d"}, {16'd0, bus.ram_d}, {16'd0, d});
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    if (w) ref_mem[a] = d;
    last_t = v.eid;
    @(posedge clk); #1;
    chk({nm, ":rsp"}, {27'd0, bus.rsp_valid, bus.rsp_id, bus.ram_r, bus.ram_w, bus.busy},
        {27'd0, 1'b1, v.eid, 2'b00, 1'b1});
    if (!w) chk({nm, ":rdata"}, {16'd0, bus.rdata}, {16'd0, v.erd});
    @(posedge clk); #1;
    chk({nm, ":idle"}, {30'd0, bus.busy, bus.rsp_valid}, 32'd0);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_t = 1'b1;
  endtask

  initial begin
    logic [6:0] aset [7];
    vec_t v;
    aset[0] = 7'd0; aset[1] = 7'd10; aset[2] = 7'd20; aset[3] = 7'd30;
    aset[4] = 7'd45; aset[5] = 7'd60; aset[6] = 7'd127;
    vt[0]  = '{1, 1, 7'd60,  16'h0100, 0, 0, 7'd0,   16'h0000, 1'b0, 16'h0000};
    vt[1]  = '{0, 0, 7'd0,   16'h0000, 1, 0, 7'd60,  16'h0000, 1'b1, 16'h0100};
    vt[2]  = '{0, 0, 7'd0,   16'h0000, 1, 1, 7'd45,  16'h0040, 1'b1, 16'h0000};
    vt[3]  = '{1, 0, 7'd45,  16'h0000, 0, 0, 7'd0,   16'h0000, 1'b0, 16'h0040};
    vt[4]  = '{1, 1, 7'd10,  16'h1111, 1, 1, 7'd10,  16'h1111, RR,   16'h0000};
    vt[5]  = '{1, 0, 7'd10,  16'h0000, 0, 0, 7'd0,   16'h0000, 1'b0, 16'h1111};
    vt[6]  = '{0, 0, 7'd0,   16'h0000, 1, 1, 7'd127, 16'hFFFF, 1'b1, 16'h0000};
    vt[7]  = '{1, 0, 7'd127, 16'h0000, 0, 0, 7'd0,   16'h0000, 1'b0, 16'hFFFF};
    vt[8]  = '{0, 0, 7'd0,   16'h0000, 1, 1, 7'd0,   16'hA5A5, 1'b1, 16'h0000};
    vt[9]  = '{1, 0, 7'd0,   16'h0000, 0, 0, 7'd0,   16'h0000, 1'b0, 16'hA5A5};
    vt[10] = '{1, 0, 7'd60,  16'h0000, 1, 0, 7'd45,  16'h0000, RR,   RR ? 16'h0040 : 16'h0100};
    vt[11] = '{0, 0, 7'd0,   16'h0000, 1, 1, 7'd60,  16'h1234, 1'b1, 16'h0000};
    vt[12] = '{1, 0, 7'd60,  16'h0000, 0, 0, 7'd0,   16'h0000, 1'b0, 16'h1234};
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 7'd0; bus.wd0 = 16'd0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 7'd0; bus.wd1 = 16'd0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst:ctl", {26'd0, bus.gnt0, bus.gnt1, bus.ram_r, bus.ram_w, bus.rsp_valid, bus.busy}, 32'd0);
      chk("rst:regs", {bus.rsp_id, bus.ram_addr, bus.ram_d, bus.rdata}, 40'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst:first_gnt", {30'd0, bus.gnt0, bus.busy}, 32'd3);
    bus.req0 = 1'b0;
    @(posedge clk); #1;
    chk("rst:first_rsp", {30'd0, bus.rsp_valid, bus.rsp_id}, 32'd2);
    @(posedge clk); #1;
    last_t = 1'b0;
    for (int i = 0; i < 13; i++) txn(vt[i], $sformatf("vec%0d", i));
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      v = '{1, 1, 7'd30, 16'h0A0A, 1, 1, 7'd31, 16'h0B0B, RR & k[0], 16'h0000};
      txn(v, $sformatf("tie%0d", k));
    end
    v = '{0, 0, 7'd0, 16'h0000, 1, 0, 7'd30, 16'h0000, 1'b1, 16'h0A0A};
    txn(v, "tie_rd");
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 7'd20; bus.wd0 = 16'h3333;
    @(posedge clk); #1;
    chk("abort:ram_w", {31'd0, bus.ram_w}, 32'd1);
    bus.req0 = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort:drop", {28'd0, bus.gnt0, bus.ram_w, bus.busy, bus.rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("abort:no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    rst_n = 1'b1;
    last_t = 1'b1;
    v = '{1, 1, 7'd20, 16'h3333, 0, 0, 7'd0, 16'h0000, 1'b0, 16'h0000};
    txn(v, "reissue");
    v = '{0, 0, 7'd0, 16'h0000, 1, 0, 7'd20, 16'h0000, 1'b1, 16'h3333};
    txn(v, "reissue_rd");
    for (int it = 0; it < 150; it++) begin
      v.r0 = 1'($urandom_range(0, 1));
      v.r1 = v.r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      v.w0 = 1'($urandom_range(0, 1));
      v.w1 = 1'($urandom_range(0, 1));
      v.a0 = aset[$urandom_range(0, 6)];
      v.a1 = aset[$urandom_range(0, 6)];
      v.d0 = 16'($urandom);
      v.d1 = 16'($urandom);
      v.eid = (v.r0 && v.r1) ? (RR & ~last_t) : v.r1;
      v.erd = ref_mem[v.eid ? v.a1 : v.a0];
      txn(v, $sformatf("rnd%0d", it));
    end
    chk("strobe_overlap", {31'd0, overlap}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
